// File: rtl/not_16.sv
// Single-stage valid/ready pipeline that registers the bitwise inverse of each accepted word.
// Optional NOT16_MASK_EN adds mask_i so the output becomes in_i ^ mask_i instead of ~in_i.
module not_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [4:0]       pop_o,
`ifdef NOT16_MASK_EN
   output logic             zero_o,
   input  logic [WIDTH-1:0] mask_i
`else
   output logic             zero_o
`endif
);

   logic [WIDTH-1:0] r_out;
   logic             r_valid;
   logic [WIDTH-1:0] w_mask;
   logic             w_accept;
   logic [4:0]       w_pop;

`ifdef NOT16_MASK_EN
   assign w_mask = mask_i;
`else
   assign w_mask = {WIDTH{1'b1}};
`endif

   // A free output slot or a draining one lets a new word in with no bubble.
   assign in_ready_o = ~r_valid | out_ready_i;
   assign w_accept   = in_valid_i & in_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_out   <= in_i ^ w_mask;
         r_valid <= 1'b1;
      end else if (out_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_pop = w_pop + {4'b0, r_out[i]};
      end
   end

   assign out_o       = r_out;
   assign out_valid_o = r_valid;
   assign pop_o       = w_pop;
   assign zero_o      = (r_out == '0);

endmodule

// File: tb/tb_not_16.sv
// Directed bench for not_16: stream, zero flag, backpressure, async reset mid-stall,
// and the masked variant when NOT16_MASK_EN is defined.
module tb_not_16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] in_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] out_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [4:0]  pop_o;
   logic        zero_o;
`ifdef NOT16_MASK_EN
   logic [15:0] mask_i;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   not_16 #(.WIDTH(16)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_i        (in_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_o       (out_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .pop_o       (pop_o),
`ifdef NOT16_MASK_EN
      .zero_o      (zero_o),
      .mask_i      (mask_i)
`else
      .zero_o      (zero_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_chk++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] exp_out, input logic [4:0] exp_pop);
      chk({tag, "_out"},   out_o,                exp_out);
      chk({tag, "_valid"}, {15'b0, out_valid_o}, 16'd1);
      chk({tag, "_pop"},   {11'b0, pop_o},       {11'b0, exp_pop});
      chk({tag, "_zero"},  {15'b0, zero_o},      {15'b0, (exp_out == 16'h0000)});
   endtask

   logic [15:0] stim_in  [5] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h3BF1};
   logic [15:0] stim_out [5] = '{16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA, 16'hC40E};
   logic [4:0]  stim_pop [5] = '{5'd16, 5'd0, 5'd8, 5'd8, 5'd6};

   initial begin
      rst_i       = 1'b1;
      in_i        = 16'h0000;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
`ifdef NOT16_MASK_EN
      mask_i      = 16'hFFFF;
`endif

      // Reset state
      @(negedge clk_i);
      chk("rst_out",   out_o,                16'h0000);
      chk("rst_valid", {15'b0, out_valid_o}, 16'd0);
      chk("rst_ready", {15'b0, in_ready_o},  16'd1);
      chk("rst_pop",   {11'b0, pop_o},       16'd0);
      chk("rst_zero",  {15'b0, zero_o},      16'd1);
      rst_i = 1'b0;

      // Back-to-back stream, first word accepted on first edge after reset
      for (int k = 0; k < 5; k++) begin
         in_i       = stim_in[k];
         in_valid_i = 1'b1;
         @(negedge clk_i);
         chk_out($sformatf("stream%0d", k), stim_out[k], stim_pop[k]);
      end

      // Consume without accept: valid drops, data holds
      in_valid_i = 1'b0;
      in_i       = 16'h1111;
      @(negedge clk_i);
      chk("drain_valid", {15'b0, out_valid_o}, 16'd0);
      chk("drain_hold",  out_o,                16'hC40E);

      // Zero flag
      in_i       = 16'hFFFF;
      in_valid_i = 1'b1;
      @(negedge clk_i);
      chk_out("zero", 16'h0000, 5'd0);
      in_valid_i = 1'b0;
      @(negedge clk_i);

      // Backpressure
      in_i       = 16'hAAAA;
      in_valid_i = 1'b1;
      @(negedge clk_i);
      chk_out("bp_first", 16'h5555, 5'd8);
      in_i        = 16'h1234;
      out_ready_i = 1'b0;
      #1;
      chk("bp_ready0", {15'b0, in_ready_o}, 16'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk_out($sformatf("bp_stall%0d", k), 16'h5555, 5'd8);
         chk($sformatf("bp_stall%0d_ready", k), {15'b0, in_ready_o}, 16'd0);
      end
      out_ready_i = 1'b1;
      #1;
      chk("bp_release_ready", {15'b0, in_ready_o}, 16'd1);
      @(negedge clk_i);
      chk_out("bp_next", 16'hEDCB, 5'd11);
      in_valid_i = 1'b0;
      @(negedge clk_i);
      chk("bp_drain_valid", {15'b0, out_valid_o}, 16'd0);

      // Async reset during a stall discards the held result
      in_i        = 16'hAAAA;
      in_valid_i  = 1'b1;
      out_ready_i = 1'b0;
      @(negedge clk_i);
      chk_out("rs_hold", 16'h5555, 5'd8);
      in_valid_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("rs_out",   out_o,                16'h0000);
      chk("rs_valid", {15'b0, out_valid_o}, 16'd0);
      chk("rs_ready", {15'b0, in_ready_o},  16'd1);
      chk("rs_zero",  {15'b0, zero_o},      16'd1);
      chk("rs_pop",   {11'b0, pop_o},       16'd0);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rs_idle_valid", {15'b0, out_valid_o}, 16'd0);

      // First accept after reset
      in_i        = 16'h3BF1;
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      chk_out("post_rst", 16'hC40E, 5'd6);

`ifdef NOT16_MASK_EN
      mask_i = 16'h00FF;
      in_i   = 16'h3BF1;
      @(negedge clk_i);
      chk_out("mask", 16'h3B0E, 5'd8);
      mask_i = 16'hF0F0;
      in_i   = 16'h0000;
      @(negedge clk_i);
      chk_out("mask2", 16'hF0F0, 5'd8);
`endif

      in_valid_i = 1'b0;
      @(negedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/not_16.md
NOT_16 -- requirements
Module: not_16

Interface
REQ-001 Parameter: WIDTH, 16, data width in bits; only 16 is supported.
REQ-002 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_i  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_i  input  16  input data word.
REQ-005 Port: in_valid_i  input  1  in_i holds a valid word.
REQ-006 Port: in_ready_o  output  1  block can accept a word this cycle.
REQ-007 Port: out_o  output  16  registered bitwise-inverted word.
REQ-008 Port: out_valid_o  output  1  out_o holds a valid result.
REQ-009 Port: out_ready_i  input  1  downstream accepts out_o this cycle.
REQ-010 Port: pop_o  output  5  number of 1 bits in out_o, range 0..16.
REQ-011 Port: zero_o  output  1  out_o equals 16'h0000.

Function
REQ-012 The block SHALL be a single-stage registered pipeline: out_o = ~in_i, bit for bit, for every accepted word.
REQ-013 A word SHALL be accepted on a rising edge when in_valid_i and in_ready_o are both 1.
REQ-014 in_ready_o SHALL equal (!out_valid_o) | out_ready_i, computed combinationally.
REQ-015 Latency SHALL be 1 cycle: a word accepted at edge N appears on out_o with out_valid_o=1 after edge N.
REQ-016 A result SHALL be consumed on an edge where out_valid_o and out_ready_i are both 1.
REQ-017 On consume with no new accept, out_valid_o SHALL go to 0 and out_o SHALL hold its last value.
REQ-018 On simultaneous consume and accept, the new result SHALL replace the old one and out_valid_o SHALL stay 1, giving full throughput with no bubble.
REQ-019 While out_valid_o=1 and out_ready_i=0, out_o SHALL hold stable and no input SHALL be accepted.
REQ-020 pop_o and zero_o SHALL be combinational functions of the registered out_o.
REQ-021 pop_o and zero_o SHALL be valid whenever out_valid_o=1, and are don't-care otherwise.
REQ-022 in_i SHALL be ignored when in_valid_i=0 or in_ready_o=0.

Reset
REQ-023 Asserting rst_i SHALL immediately set out_o=16'h0000 and out_valid_o=0, regardless of clk_i.
REQ-024 During reset, in_ready_o SHALL read 1, pop_o SHALL read 0 and zero_o SHALL read 1.
REQ-025 Reset asserted mid-stall SHALL discard the held result.
REQ-026 After reset deasserts, the first accept SHALL occur on the first rising edge with in_valid_i=1.

Configuration
REQ-027 With the macro NOT16_MASK_EN defined, the block SHALL add port mask_i (input, 16 bits).
REQ-028 With NOT16_MASK_EN defined, each accepted word SHALL produce out_o = in_i ^ mask_i, with mask_i sampled on the same edge as in_i.
REQ-029 With NOT16_MASK_EN undefined, the mask_i port SHALL not exist and the mask SHALL be fixed at 16'hFFFF, giving a pure NOT.

Verification
REQ-030 Stream, one word per cycle, out_ready_i=1: in_i 0000, FFFF, AAAA, 5555, 3BF1 -> out_o FFFF, 0000, 5555, AAAA, C40E, each 1 cycle after accept; pop_o 16, 0, 8, 8, 6.
REQ-031 Zero flag: accept in_i=FFFF -> out_o=0000, zero_o=1, pop_o=0.
REQ-032 Backpressure: accept AAAA, hold out_ready_i=0 for 3 cycles while presenting 1234 -> out_o stays 5555 and in_ready_o=0; release -> 5555 consumed, then 1234 accepted -> out_o=EDCB.
REQ-033 Reset mid-stall: out_valid_o=1 holding 5555, pulse rst_i between clock edges -> out_o=0000 and out_valid_o=0 immediately.
REQ-034 With NOT16_MASK_EN defined: in_i=3BF1, mask_i=00FF -> out_o=3B0E, pop_o=8.
